// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_skid
//  Purpose  : Pipeline stage with a main register and one skid register.
//             It also keeps a saturating count of downstream stall cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int CTRL_W      = 11,
    parameter int DATA_W      = 138,
    parameter int BUBBLE_ZERO = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_TWO   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              r_in_ready;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_out_valid;
    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_out_valid = (r_state != c_EMPTY);
    assign w_in_fire   = in_valid && r_in_ready;
    assign w_out_fire  = w_out_valid && out_ready;

    // Occupancy transitions; flush squashes everything including a same-cycle accept.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            c_EMPTY: begin
                if (w_in_fire) begin
                    w_next_state   = c_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            c_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_out_fire) begin
                    w_next_state = c_EMPTY;
                end else if (w_in_fire) begin
                    w_next_state = c_TWO;
                    w_load_skid  = 1'b1;
                end
            end
            c_TWO: begin
                if (w_out_fire) begin
                    w_next_state     = c_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_next_state = c_EMPTY;
            end
        endcase
        if (flush) begin
            w_next_state     = c_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_EMPTY;
            r_in_ready  <= 1'b1;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state    <= w_next_state;
            // Registered ready breaks any combinational path from out_ready.
            r_in_ready <= (w_next_state != c_TWO);
            if (w_load_main_in) begin
                r_main_ctrl <= ctrl_in;
                r_main_data <= data_in;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= ctrl_in;
                r_skid_data <= data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    generate
        if (BUBBLE_ZERO != 0) begin : g_bubble_zero
            assign ctrl_out = w_out_valid ? r_main_ctrl : '0;
        end else begin : g_bubble_pass
            assign ctrl_out = r_main_ctrl;
        end
    endgenerate

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign data_out  = r_main_data;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_skid
//  Purpose  : Directed and randomized self-checking bench for pipe_stage_skid.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int CTRL_W = 11;
    localparam int DATA_W = 138;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] ctrl_out;
    logic [DATA_W-1:0] data_out;
    logic [CNT_W-1:0]  stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_stage_skid #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .BUBBLE_ZERO(1), .CNT_W(CNT_W)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl_in(ctrl_in), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .ctrl_out(ctrl_out), .data_out(data_out),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mk_data(input logic [CTRL_W-1:0] c);
        return {~c, 116'h5A5A_0000_0000_0000_0000_0000_1234_5, c};
    endfunction

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [CTRL_W-1:0] c);
        in_valid = v;
        ctrl_in  = c;
        data_in  = mk_data(c);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    logic [CTRL_W-1:0] q[$];
    logic [CTRL_W-1:0] exp_c;
    logic              w_in_f;
    logic              w_out_f;

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        send(1'b0, '0);
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_ctrl_out", ctrl_out, 0);
        check("rst_data_out", data_out, 0);
        check("rst_stall", stall_cnt, 0);
        rst_n = 1'b1;

        // Streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send(1'b1, CTRL_W'(i));
            step();
            check("stream_ctrl", ctrl_out, i);
            check("stream_data", data_out, mk_data(CTRL_W'(i)));
            check("stream_in_ready", in_ready, 1);
        end
        send(1'b0, '0);
        step();
        check("stream_drain_valid", out_valid, 0);
        check("stream_drain_ctrl", ctrl_out, 0);
        check("stream_stall", stall_cnt, 0);

        // Backpressure fills skid
        out_ready = 1'b0;
        send(1'b1, 11'h0AA);
        step();
        check("bp_ctrl_a", ctrl_out, 11'h0AA);
        check("bp_in_ready_one", in_ready, 1);
        send(1'b1, 11'h0BB);
        step();
        check("bp_in_ready_two", in_ready, 0);
        check("bp_hold_a", ctrl_out, 11'h0AA);
        check("bp_stall1", stall_cnt, 1);
        send(1'b1, 11'h0EE);
        step();
        check("bp_hold_a2", ctrl_out, 11'h0AA);
        check("bp_stall2", stall_cnt, 2);
        send(1'b0, '0);
        out_ready = 1'b1;
        step();
        check("bp_rel_b", ctrl_out, 11'h0BB);
        check("bp_rel_b_data", data_out, mk_data(11'h0BB));
        check("bp_rel_in_ready", in_ready, 1);
        step();
        check("bp_empty", out_valid, 0);
        check("bp_stall_kept", stall_cnt, 2);

        // Flush in TWO with a simultaneous input
        out_ready = 1'b0;
        send(1'b1, 11'h0DD);
        step();
        send(1'b1, 11'h0EE);
        step();
        check("fl_pre_in_ready", in_ready, 0);
        check("fl_pre_stall", stall_cnt, 3);
        flush = 1'b1;
        send(1'b1, 11'h0CC);
        step();
        flush = 1'b0;
        check("fl_valid", out_valid, 0);
        check("fl_ctrl", ctrl_out, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_stall_kept", stall_cnt, 4);
        send(1'b0, '0);
        out_ready = 1'b1;
        step();
        check("fl_no_c", out_valid, 0);

        // Stall counter saturation
        do_reset();
        out_ready = 1'b0;
        send(1'b1, 11'h111);
        step();
        send(1'b0, '0);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 14) check("sat_14", stall_cnt, 14);
            if (k == 15) check("sat_15", stall_cnt, 15);
        end
        check("sat_20", stall_cnt, 15);
        check("sat_hold_ctrl", ctrl_out, 11'h111);

        // Reset while in TWO with stall_cnt=5
        do_reset();
        out_ready = 1'b0;
        send(1'b1, 11'h051);
        step();
        send(1'b1, 11'h052);
        step();
        send(1'b0, '0);
        for (int k = 0; k < 4; k++) step();
        check("mr_pre_stall", stall_cnt, 5);
        check("mr_pre_in_ready", in_ready, 0);
        rst_n = 1'b0;
        flush = 1'b1;
        out_ready = 1'b1;
        send(1'b1, 11'h0FF);
        step();
        flush = 1'b0;
        check("mr_valid", out_valid, 0);
        check("mr_in_ready", in_ready, 1);
        check("mr_ctrl", ctrl_out, 0);
        check("mr_data", data_out, 0);
        check("mr_stall", stall_cnt, 0);
        rst_n = 1'b1;
        send(1'b1, 11'h061);
        step();
        check("mr_resume_ctrl", ctrl_out, 11'h061);
        check("mr_resume_valid", out_valid, 1);
        send(1'b0, '0);
        step();
        check("mr_resume_drain", out_valid, 0);

        // Random traffic against a FIFO scoreboard
        do_reset();
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            send(1'($urandom_range(0, 1)), CTRL_W'($urandom));
            check("rnd_out_valid", out_valid, (q.size() > 0));
            check("rnd_in_ready", in_ready, (q.size() < 2));
            w_in_f  = in_valid && in_ready;
            w_out_f = out_valid && out_ready;
            if (w_out_f) begin
                exp_c = (q.size() > 0) ? q[0] : '0;
                check("rnd_ctrl", ctrl_out, exp_c);
                check("rnd_data", data_out, mk_data(exp_c));
                if (q.size() > 0) void'(q.pop_front());
            end
            if (w_in_f) q.push_back(ctrl_in);
            step();
        end
        send(1'b0, '0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (out_valid) begin
                exp_c = (q.size() > 0) ? q[0] : '0;
                check("rnd_tail_ctrl", ctrl_out, exp_c);
                if (q.size() > 0) void'(q.pop_front());
            end
            step();
        end
        check("rnd_all_out", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
